// File: rtl/ddr3_cmd_sched.sv
// ddr3_cmd_sched: round-robin DDR3 command arbiter enforcing tRRD/tCCD/tRFC with registered command pins
package ddr3_pkg;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF} ddr3_cmd_t;
endpackage

module ddr3_cmd_sched
  import ddr3_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W = 14,
  parameter int T_RRD = 4,
  parameter int T_CCD = 4,
  parameter int T_RFC = 32,
  localparam int BA_W = $clog2(NUM_BANKS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_BANKS-1:0] bank_cmd_valid,
  input  ddr3_cmd_t [NUM_BANKS-1:0] bank_cmd_type,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS-1:0] bank_cmd_ready,
  output logic [BA_W-1:0] next_prio_bank,
  input  logic refresh_cmd_valid,
  output logic refresh_cmd_ready,
  output logic refresh_busy,
  output logic ddr3_ras_n,
  output logic ddr3_cas_n,
  output logic ddr3_we_n,
  output logic [BA_W-1:0] ddr3_ba,
  output logic [ADDR_W-1:0] ddr3_addr
);
  localparam int RW = $clog2(T_RRD + 1);
  localparam int CW = $clog2(T_CCD + 1);
  localparam int FW = $clog2(T_RFC);
  typedef enum logic {ARB, REF_WAIT} state_t;
  state_t state;
  logic [BA_W-1:0] prio, gnt_idx, idx;
  logic [RW-1:0] act_timer;
  logic [CW-1:0] cas_timer;
  logic [FW-1:0] rfc_cnt;
  logic [NUM_BANKS-1:0] elig;
  logic arb_ok, gnt, is_act, is_cas, bank_live;
  logic [2:0] pins;
  ddr3_cmd_t gnt_type;
  assign arb_ok = rst_n && state == ARB && !refresh_cmd_valid;
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_elig
    assign elig[i] = arb_ok && bank_cmd_valid[i] &&
      (bank_cmd_type[i] == CMD_ACT ? act_timer == '0 :
       (bank_cmd_type[i] == CMD_READ || bank_cmd_type[i] == CMD_WRITE) ? cas_timer == '0 : 1'b1);
  end
  // Scan from the priority pointer; power-of-two bank count makes the wrap free.
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int j = 0; j < NUM_BANKS; j++) begin
      idx = prio + BA_W'(j);
      if (!gnt && elig[idx]) begin
        gnt = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign gnt_type = bank_cmd_type[gnt_idx];
  assign bank_cmd_ready = gnt ? NUM_BANKS'(1) << gnt_idx : '0;
  assign refresh_cmd_ready = rst_n && state == ARB && refresh_cmd_valid;
  assign refresh_busy = rst_n && state == REF_WAIT;
  assign next_prio_bank = gnt ? gnt_idx + BA_W'(1) : prio;
  assign is_act = gnt && gnt_type == CMD_ACT;
  assign is_cas = gnt && (gnt_type == CMD_READ || gnt_type == CMD_WRITE);
  // NOP and undefined bank commands are consumed but leave the bus idle.
  always_comb begin
    pins = refresh_cmd_ready ? 3'b001 :
           !gnt ? 3'b111 :
           gnt_type == CMD_ACT ? 3'b011 :
           gnt_type == CMD_READ ? 3'b101 :
           gnt_type == CMD_WRITE ? 3'b100 :
           gnt_type == CMD_PRE ? 3'b010 : 3'b111;
  end
  assign bank_live = gnt && pins != 3'b111;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB;
      prio <= '0;
      act_timer <= '0;
      cas_timer <= '0;
      rfc_cnt <= '0;
      {ddr3_ras_n, ddr3_cas_n, ddr3_we_n} <= 3'b111;
      ddr3_ba <= '0;
      ddr3_addr <= '0;
    end else begin
      prio <= next_prio_bank;
      act_timer <= is_act ? RW'(T_RRD - 1) : act_timer == '0 ? '0 : act_timer - RW'(1);
      cas_timer <= is_cas ? CW'(T_CCD - 1) : cas_timer == '0 ? '0 : cas_timer - CW'(1);
      {ddr3_ras_n, ddr3_cas_n, ddr3_we_n} <= pins;
      ddr3_ba <= bank_live ? gnt_idx : '0;
      ddr3_addr <= bank_live ? bank_addr[gnt_idx] : '0;
      if (refresh_cmd_ready) begin
        state <= REF_WAIT;
        rfc_cnt <= FW'(T_RFC - 1);
      end else if (state == REF_WAIT) begin
        rfc_cnt <= rfc_cnt - FW'(1);
        if (rfc_cnt == FW'(1)) state <= ARB;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// tb_ddr3_cmd_sched: directed scenarios plus randomized traffic against a cycle-stamp reference model
module tb_ddr3_cmd_sched;
  import ddr3_pkg::*;
  localparam int NB = 8, AW = 14, BW = 3, T_RRD = 4, T_CCD = 4, T_RFC = 32;
  localparam int PW = 3 + BW + AW;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, ref_valid, ref_ready, busy, ras, cas, we;
  logic [NB-1:0] valid, ready;
  ddr3_cmd_t [NB-1:0] ctype;
  logic [NB-1:0][AW-1:0] addr;
  logic [BW-1:0] np, ba;
  logic [AW-1:0] daddr;
  logic [PW-1:0] pins;
  logic [NB-1:0] s_ready;
  logic s_ref_ready, s_busy;
  logic [BW-1:0] s_np;
  int n_vec = 0, n_err = 0;
  assign pins = {ras, cas, we, ba, daddr};

  ddr3_cmd_sched #(.NUM_BANKS(NB), .ADDR_W(AW), .T_RRD(T_RRD), .T_CCD(T_CCD), .T_RFC(T_RFC)) dut (
    .clk(clk), .rst_n(rst_n), .bank_cmd_valid(valid), .bank_cmd_type(ctype), .bank_addr(addr),
    .bank_cmd_ready(ready), .next_prio_bank(np), .refresh_cmd_valid(ref_valid),
    .refresh_cmd_ready(ref_ready), .refresh_busy(busy), .ddr3_ras_n(ras), .ddr3_cas_n(cas),
    .ddr3_we_n(we), .ddr3_ba(ba), .ddr3_addr(daddr));

  task automatic cycle();
    @(negedge clk);
    s_ready = ready;
    s_ref_ready = ref_ready;
    s_busy = busy;
    s_np = np;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    ref_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] code(ddr3_cmd_t t);
    case (t)
      CMD_ACT: return 3'b011;
      CMD_READ: return 3'b101;
      CMD_WRITE: return 3'b100;
      CMD_PRE: return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [PW-1:0] bank_pins(int b);
    logic [2:0] c;
    c = code(ctype[b]);
    return c == 3'b111 ? {3'b111, BW'(0), AW'(0)} : {c, BW'(b), addr[b]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ref_valid = 1'b0;
    valid = '1;
    for (int i = 0; i < NB; i++) begin
      ctype[i] = CMD_PRE;
      addr[i] = AW'(16'h100 + i);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_vec++;
      if ({s_ready, s_ref_ready, s_busy} !== '0) begin
        n_err++;
        $display("FAIL reset_ready: got %h/%b/%b expected 0/0/0", s_ready, s_ref_ready, s_busy);
      end
      n_vec++;
      if (pins !== {3'b111, BW'(0), AW'(0)}) begin
        n_err++;
        $display("FAIL reset_pins: got %h expected %h", pins, {3'b111, BW'(0), AW'(0)});
      end
    end
    rst_n = 1'b1;
    cycle();
    n_vec++;
    if (s_ready !== 8'h01 || pins !== {3'b010, BW'(0), AW'(16'h100)}) begin
      n_err++;
      $display("FAIL first_grant: got ready %h pins %h expected 01 %h", s_ready, pins, {3'b010, BW'(0), AW'(16'h100)});
    end
    valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    valid = '1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      n_vec++;
      if (s_ready !== NB'(1) << (k % NB) || s_np !== BW'((k + 1) % NB)) begin
        n_err++;
        $display("FAIL rr_grant %0d: got ready %h prio %0d expected %h %0d", k, s_ready, s_np, NB'(1) << (k % NB), (k + 1) % NB);
      end
      n_vec++;
      if (pins !== {3'b010, BW'(k % NB), AW'(16'h100 + k % NB)}) begin
        n_err++;
        $display("FAIL rr_pins %0d: got %h expected %h", k, pins, {3'b010, BW'(k % NB), AW'(16'h100 + k % NB)});
      end
    end
    valid = '0;
  endtask

  task automatic test_trrd();
    int g[5] = '{2, -1, -1, -1, 5};
    do_reset();
    ctype[2] = CMD_ACT;
    addr[2] = AW'(16'h1A5);
    ctype[5] = CMD_ACT;
    addr[5] = AW'(16'h0FF);
    valid[2] = 1'b1;
    valid[5] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_vec++;
      if (s_ready !== (g[k] < 0 ? NB'(0) : NB'(1) << g[k])) begin
        n_err++;
        $display("FAIL trrd_ready %0d: got %h expected bank %0d", k, s_ready, g[k]);
      end
      n_vec++;
      if (pins !== (g[k] < 0 ? {3'b111, BW'(0), AW'(0)} : {3'b011, BW'(g[k]), addr[g[k]]})) begin
        n_err++;
        $display("FAIL trrd_pins %0d: got %h expected bank %0d", k, pins, g[k]);
      end
      if (g[k] >= 0) valid[g[k]] = 1'b0;
    end
  endtask

  task automatic test_tccd();
    int g[4] = '{3, -1, -1, 1};
    logic [2:0] c[4] = '{3'b010, 3'b111, 3'b111, 3'b100};
    do_reset();
    ctype[1] = CMD_READ;
    addr[1] = AW'(16'h033);
    valid[1] = 1'b1;
    cycle();
    n_vec++;
    if (s_ready !== 8'h02 || pins !== {3'b101, BW'(1), AW'(16'h033)}) begin
      n_err++;
      $display("FAIL tccd_read: got ready %h pins %h expected 02 %h", s_ready, pins, {3'b101, BW'(1), AW'(16'h033)});
    end
    ctype[1] = CMD_WRITE;
    addr[1] = AW'(16'h044);
    ctype[3] = CMD_PRE;
    addr[3] = AW'(16'h055);
    valid[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_vec++;
      if (s_ready !== (g[k] < 0 ? NB'(0) : NB'(1) << g[k]) ||
          pins !== (g[k] < 0 ? {3'b111, BW'(0), AW'(0)} : {c[k], BW'(g[k]), addr[g[k]]})) begin
        n_err++;
        $display("FAIL tccd_skip %0d: got ready %h pins %h expected bank %0d", k, s_ready, pins, g[k]);
      end
      if (g[k] >= 0) valid[g[k]] = 1'b0;
    end
  endtask

  task automatic test_refresh();
    do_reset();
    ref_valid = 1'b1;
    ctype[0] = CMD_ACT;
    addr[0] = AW'(16'h123);
    valid[0] = 1'b1;
    cycle();
    n_vec++;
    if ({s_ref_ready, s_ready} !== {1'b1, 8'h00} || pins !== {3'b001, BW'(0), AW'(0)}) begin
      n_err++;
      $display("FAIL ref_grant: got ref %b ready %h pins %h expected 1 00 %h", s_ref_ready, s_ready, pins, {3'b001, BW'(0), AW'(0)});
    end
    ref_valid = 1'b0;
    for (int k = 1; k <= T_RFC; k++) begin
      cycle();
      n_vec++;
      if ({s_busy, s_ready} !== {k < T_RFC, k == T_RFC ? 8'h01 : 8'h00}) begin
        n_err++;
        $display("FAIL rfc_window %0d: got busy %b ready %h expected %b %h", k, s_busy, s_ready, k < T_RFC, k == T_RFC ? 8'h01 : 8'h00);
      end
    end
    n_vec++;
    if (pins !== {3'b011, BW'(0), AW'(16'h123)}) begin
      n_err++;
      $display("FAIL rfc_resume_pins: got %h expected %h", pins, {3'b011, BW'(0), AW'(16'h123)});
    end
    valid = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    ref_valid = 1'b1;
    cycle();
    ref_valid = 1'b0;
    repeat (9) cycle();
    n_vec++;
    if (s_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_busy_before: got %b expected 1", s_busy);
    end
    rst_n = 1'b0;
    cycle();
    n_vec++;
    if (s_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_busy_during: got %b expected 0", s_busy);
    end
    rst_n = 1'b1;
    ctype[6] = CMD_READ;
    addr[6] = AW'(16'h0AB);
    valid[6] = 1'b1;
    cycle();
    n_vec++;
    if ({s_busy, s_ready} !== {1'b0, 8'h40} || pins !== {3'b101, BW'(6), AW'(16'h0AB)}) begin
      n_err++;
      $display("FAIL midrst_regrant: got busy %b ready %h pins %h expected 0 40 %h", s_busy, s_ready, pins, {3'b101, BW'(6), AW'(16'h0AB)});
    end
    valid = '0;
  endtask

  task automatic test_random();
    int cyc = 0, last_act = -100, last_cas = -100, ref_end = 0, m_prio = 0, e_gnt;
    logic e_ref, e_busy;
    logic [2:0] r;
    logic [PW-1:0] e_pins;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NB; b++) begin
        if (!valid[b] && $urandom_range(0, 2) == 0) begin
          r = 3'($urandom_range(0, 6));
          ctype[b] = ddr3_cmd_t'(r >= 3'd5 ? r + 3'd1 : r);
          addr[b] = AW'($urandom);
          valid[b] = 1'b1;
        end
      end
      if (!ref_valid && $urandom_range(0, 59) == 0) ref_valid = 1'b1;
      e_busy = cyc < ref_end;
      e_ref = !e_busy && ref_valid;
      e_gnt = -1;
      if (!e_busy && !ref_valid) begin
        for (int j = 0; j < NB; j++) begin
          int b = (m_prio + j) % NB;
          if (e_gnt < 0 && valid[b] &&
              (ctype[b] == CMD_ACT ? cyc - last_act >= T_RRD :
               (ctype[b] == CMD_READ || ctype[b] == CMD_WRITE) ? cyc - last_cas >= T_CCD : 1'b1))
            e_gnt = b;
        end
      end
      e_pins = e_ref ? {3'b001, BW'(0), AW'(0)} : e_gnt < 0 ? {3'b111, BW'(0), AW'(0)} : bank_pins(e_gnt);
      cycle();
      n_vec++;
      if (s_ready !== (e_gnt < 0 ? NB'(0) : NB'(1) << e_gnt)) begin
        n_err++;
        $display("FAIL rnd_ready @%0d: got %h expected bank %0d", cyc, s_ready, e_gnt);
      end
      n_vec++;
      if ({s_ref_ready, s_busy} !== {e_ref, e_busy}) begin
        n_err++;
        $display("FAIL rnd_refresh @%0d: got %b%b expected %b%b", cyc, s_ref_ready, s_busy, e_ref, e_busy);
      end
      n_vec++;
      if (s_np !== BW'(e_gnt < 0 ? m_prio : (e_gnt + 1) % NB)) begin
        n_err++;
        $display("FAIL rnd_prio @%0d: got %0d expected %0d", cyc, s_np, e_gnt < 0 ? m_prio : (e_gnt + 1) % NB);
      end
      n_vec++;
      if (pins !== e_pins) begin
        n_err++;
        $display("FAIL rnd_pins @%0d: got %h expected %h", cyc, pins, e_pins);
      end
      if (e_gnt >= 0) begin
        m_prio = (e_gnt + 1) % NB;
        if (ctype[e_gnt] == CMD_ACT) last_act = cyc;
        if (ctype[e_gnt] == CMD_READ || ctype[e_gnt] == CMD_WRITE) last_cas = cyc;
        valid[e_gnt] = 1'b0;
      end
      if (e_ref) begin
        ref_end = cyc + T_RFC;
        ref_valid = 1'b0;
      end
      cyc++;
    end
    valid = '0;
    ref_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    ref_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      ctype[i] = CMD_NOP;
      addr[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_trrd();
    test_tccd();
    test_refresh();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
